// File: rtl/jstk_spi_responder.sv
// Joystick SPI responder (SPI mode 0). It reports X/Y position and button
// state as a 40-bit frame, and it flags frames whose length is wrong.
// Optional feature: when the macro JSTK_RESP_CMD_EN is defined, the responder
// decodes an LED command from received byte 0. When the macro is undefined,
// no mosi path exists and led_out is held at 2'b00.
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [2:0] btn_in,
  output logic [1:0] led_out,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_prev_r;
  logic                   cs_prev_r;
  logic [SYNC_STAGES:0]   flush_r;
  logic                   armed_r;
  logic [39:0]            tx_r;
  logic [5:0]             cnt_r;
  logic                   miso_r;
  logic                   done_r;
  logic                   err_r;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   frame_ok_s;
  logic [39:0]            tx_load_s;
  logic [5:0]             cnt_inc_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  // sclk edges only count while the synchronized chip select is low
  assign sclk_rise_s = sclk_s & ~sclk_prev_r & ~cs_s;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r & ~cs_s;
  assign cs_fall_s   = ~cs_s & cs_prev_r;
  assign cs_rise_s   = cs_s & ~cs_prev_r;
  assign frame_ok_s  = (cnt_r == 6'd40);
  assign cnt_inc_s   = (cnt_r == 6'd63) ? cnt_r : (cnt_r + 6'd1);
  assign tx_load_s   = {x_in[7:0], 6'b000000, x_in[9:8],
                        y_in[7:0], 6'b000000, y_in[9:8],
                        5'b00000, btn_in};

  // Synchronize sclk and cs, and keep the previous value for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  // Arm frame start only after cs has really been seen high following reset.
  // The reset value of the synchronizer chain is not evidence, so it must be
  // flushed out first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_r <= {(SYNC_STAGES+1){1'b0}};
      armed_r <= 1'b0;
    end else begin
      flush_r <= {flush_r[SYNC_STAGES-1:0], 1'b1};
      if ((&flush_r) && cs_s && cs_prev_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

`ifdef JSTK_RESP_CMD_EN
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   mosi_s;
  logic [39:0]            rx_r;
  logic [1:0]             led_r;

  assign mosi_s  = mosi_sync_r[SYNC_STAGES-1];
  assign led_out = led_r;

  // Synchronize mosi in step with sclk so it is sampled on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
    end
  end

  // Receive shift register and LED command decode on a valid frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_r  <= 40'd0;
      led_r <= 2'b00;
    end else begin
      if (state_r == ST_LOAD) begin
        rx_r <= 40'd0;
      end else if ((state_r == ST_SHIFT) && !cs_rise_s && sclk_rise_s) begin
        rx_r <= {rx_r[38:0], mosi_s};
      end else begin
        rx_r <= rx_r;
      end
      if ((state_r == ST_DONE) && frame_ok_s && (rx_r[39:34] == 6'b100000)) begin
        led_r <= rx_r[33:32];
      end else begin
        led_r <= led_r;
      end
    end
  end
`else
  logic unused_mosi_s;

  assign unused_mosi_s = mosi;
  assign led_out       = 2'b00;
`endif

  // Frame FSM: transmit shifting, bit counting and done/err pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      tx_r    <= 40'd0;
      cnt_r   <= 6'd0;
      miso_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          miso_r <= 1'b0;
          cnt_r  <= 6'd0;
          if (cs_fall_s && armed_r) begin
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          tx_r    <= tx_load_s;
          miso_r  <= tx_load_s[39];
          cnt_r   <= 6'd0;
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
            if (sclk_rise_s) begin
              cnt_r <= cnt_inc_s;
            end else begin
              cnt_r <= cnt_r;
            end
            if (sclk_fall_s) begin
              // Zero fill means miso is 0 once all 40 bits have gone out
              tx_r   <= {tx_r[38:0], 1'b0};
              miso_r <= tx_r[38];
            end else begin
              tx_r   <= tx_r;
              miso_r <= miso_r;
            end
          end
        end
        ST_DONE: begin
          done_r  <= frame_ok_s;
          err_r   <= ~frame_ok_s;
          cnt_r   <= 6'd0;
          tx_r    <= 40'd0;
          miso_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 40'd0;
          cnt_r   <= 6'd0;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  assign miso       = miso_r;
  assign frame_done = done_r;
  assign frame_err  = err_r;

endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, cs and mosi (legal range 2..3).
REQ-002 Port clk, input, 1: single system clock for all logic.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port sclk, input, 1: SPI clock from the master (mode 0).
REQ-005 Port cs, input, 1: SPI chip select, active-low.
REQ-006 Port mosi, input, 1: master-to-responder data.
REQ-007 Port miso, output, 1: responder-to-master data.
REQ-008 Port x_in, input, 10: X position to report.
REQ-009 Port y_in, input, 10: Y position to report.
REQ-010 Port btn_in, input, 3: buttons {btn2, btn1, jstk}.
REQ-011 Port led_out, output, 2: LED state from the last valid command.
REQ-012 Port frame_done, output, 1: one-cycle pulse when a valid 40-bit frame completes.
REQ-013 Port frame_err, output, 1: one-cycle pulse when a frame ends with a bit count other than 40.

Function
REQ-014 Sampling: sclk, cs and mosi SHALL pass through SYNC_STAGES flip-flops, followed by one edge-detect register; all edges below refer to these synchronized signals.
REQ-015 Input timing: the master SHALL hold each SCLK half-period for at least SYNC_STAGES+2 clk cycles.
REQ-016 States: IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE -> LOAD on a cs falling edge; LOAD lasts one cycle and then moves to SHIFT.
REQ-018 LOAD SHALL snapshot a 40-bit transmit register: {x_in[7:0], 6'b0, x_in[9:8], y_in[7:0], 6'b0, y_in[9:8], 5'b0, btn_in}.
REQ-019 Transmit order: byte 0 first, MSB first within each byte.
REQ-020 In LOAD, miso SHALL take bit 39; input changes after LOAD SHALL NOT affect the frame in progress.
REQ-021 In SHIFT, each sclk rising edge SHALL shift mosi into a 40-bit receive register and increment a 6-bit bit counter that saturates at 63.
REQ-022 In SHIFT, each sclk falling edge SHALL left-shift the transmit register with zero fill; miso follows the register MSB.
REQ-023 Once 40 bits have been sent, miso SHALL remain 0.
REQ-024 miso SHALL be 0 whenever the state is IDLE.
REQ-025 SHIFT -> DONE on a cs rising edge.
REQ-026 In DONE with counter == 40: pulse frame_done.
REQ-027 In DONE with counter != 40 (including 0 and saturated): pulse frame_err; led_out unchanged.
REQ-028 DONE SHALL clear the counter and return to IDLE in the same cycle.
REQ-029 A cs falling edge seen while in LOAD or SHIFT SHALL be ignored; it cannot restart a frame.
REQ-030 sclk edges seen while cs is high SHALL be ignored.
REQ-031 Pin-to-miso latency: SYNC_STAGES+1 clk cycles from a pin sclk falling edge.
REQ-032 frame_done and frame_err SHALL never both be 1 in the same cycle.

Reset
REQ-033 Asserting rst (low) SHALL force the following within the same clock period, independent of clk:
- state = IDLE
- miso = 0
- led_out = 2'b00
- frame_done = 0, frame_err = 0
- counter = 0
- shift registers = 0
- synchronizers = 1 for cs, 0 for sclk and mosi
REQ-034 Reset asserted mid-frame SHALL abort the frame with no done/err pulse.
REQ-035 After reset release, a new frame SHALL start only on a fresh cs falling edge; a cs already low at release is ignored until it goes high and low again.

Configuration
REQ-036 With JSTK_RESP_CMD_EN defined, a valid frame (REQ-026) SHALL update led_out in the DONE cycle when received byte 0[7:2] == 6'b100000, setting led_out = byte 0[1:0].
REQ-037 With JSTK_RESP_CMD_EN defined, any other byte-0 value SHALL leave led_out unchanged.
REQ-038 Without JSTK_RESP_CMD_EN, the following SHALL be absent and led_out SHALL be tied to 2'b00:
- the mosi synchronizer
- the receive register
- the command decode
REQ-039 Without JSTK_RESP_CMD_EN, framing, frame_done and frame_err behaviour SHALL be unchanged.

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
- x_in=10'h2A5, y_in=10'h13C, btn_in=3'b101, 40-bit frame, mosi=0x00 -> master receives A5 02 3C 01 05; one frame_done pulse.
- JSTK_RESP_CMD_EN defined, mosi byte 0 = 0x83 -> led_out=2'b11 on the DONE cycle; next frame with 0x40 -> led_out stays 2'b11.
- cs rises after 24 bits -> frame_err pulse, no frame_done, led_out unchanged; the next full frame completes normally.
- 48-bit frame -> miso=0 for bits 40..47; frame_err pulse.
- rst pulsed low during bit 17 -> miso=0, no pulses; a subsequent frame returns fresh input values.
- x_in changed every clk cycle during SHIFT -> received X equals the value at LOAD.
